// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if : memory/decoder handshake bundle for the controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multicycle_controller_if;
  logic        io_halt;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic [31:0] io_instruction;
  logic        io_mem_read;
  logic        io_mem_write;
  logic        io_reg_write;
  logic        io_dmem_req_valid;
  logic        io_dmem_req_write;
  logic        io_dmem_req_ready;
  logic        io_dmem_resp_valid;
  logic        io_pc_write;
  logic        io_reg_write_enable;
  logic [2:0]  io_state;
  logic        io_halted;
  logic [31:0] io_instret;

  modport master (
    input  io_halt, io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
    input  io_mem_read, io_mem_write, io_reg_write,
    input  io_dmem_req_ready, io_dmem_resp_valid,
    output io_imem_req_valid, io_instruction, io_dmem_req_valid, io_dmem_req_write,
    output io_pc_write, io_reg_write_enable, io_state, io_halted, io_instret
  );

  modport slave (
    output io_halt, io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
    output io_mem_read, io_mem_write, io_reg_write,
    output io_dmem_req_ready, io_dmem_resp_valid,
    input  io_imem_req_valid, io_instruction, io_dmem_req_valid, io_dmem_req_write,
    input  io_pc_write, io_reg_write_enable, io_state, io_halted, io_instret
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller : fetch/decode/execute/memory/writeback sequencing FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_controller (
  input  wire logic              clock,
  input  wire logic              reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_IF_WAIT   = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM_REQ   = 3'd4,
    S_MEM_WAIT  = 3'd5,
    S_WRITEBACK = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_t;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_instret;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ir      <= c_NOP;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF_WAIT && bus.io_imem_resp_valid)
        r_ir <= bus.io_imem_resp_data;
      if (r_state == S_WRITEBACK)
        r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_next                  = r_state;
    bus.io_imem_req_valid   = 1'b0;
    bus.io_dmem_req_valid   = 1'b0;
    bus.io_dmem_req_write   = 1'b0;
    bus.io_pc_write         = 1'b0;
    bus.io_reg_write_enable = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        // Halt only gates new fetches; reset also masks the request while held.
        bus.io_imem_req_valid = !bus.io_halt && !reset;
        if (bus.io_imem_req_ready && !bus.io_halt)
          w_next = S_IF_WAIT;
      end
      S_IF_WAIT: begin
        if (bus.io_imem_resp_valid)
          w_next = S_DECODE;
      end
      S_DECODE: w_next = S_EXECUTE;
      S_EXECUTE: begin
        if (bus.io_mem_read || bus.io_mem_write)
          w_next = S_MEM_REQ;
        else
          w_next = S_WRITEBACK;
      end
      S_MEM_REQ: begin
        bus.io_dmem_req_valid = 1'b1;
        bus.io_dmem_req_write = bus.io_mem_write;
        if (bus.io_dmem_req_ready)
          w_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (bus.io_dmem_resp_valid)
          w_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        bus.io_pc_write         = 1'b1;
        bus.io_reg_write_enable = bus.io_reg_write;
        w_next                  = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.io_state       = r_state;
  assign bus.io_instruction = r_ir;
  assign bus.io_instret     = r_instret;
  assign bus.io_halted      = (r_state == S_FETCH) && bus.io_halt;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller : directed scoreboard bench for multicycle_controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controller;

  logic clock;
  logic reset;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    logic        rwe;
    logic        wr;
    logic [31:0] instret;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_instret;
  int          n_pass;
  int          n_total;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  // Drives one instruction through the controller starting from FETCH.
  task automatic run_instr(input logic [31:0] word, input logic mr, input logic mw,
                           input logic rw, input int rdy_wait, input int resp_wait,
                           input bit halt_exec);
    exp_t e;
    int   exp_cyc;
    exp_instret = exp_instret + 32'd1;
    e.word = word; e.rwe = rw; e.wr = mw; e.instret = exp_instret;
    sb.push_back(e);
    exp_cyc = (mr | mw) ? 7 + rdy_wait + resp_wait : 5;
    cyc = 0;
    bus.io_mem_read  = mr;
    bus.io_mem_write = mw;
    bus.io_reg_write = rw;
    chk("fetch_state", 32'(bus.io_state), 32'd0);
    chk("imem_req_valid", 32'(bus.io_imem_req_valid), 32'd1);
    step();
    chk("ifwait_state", 32'(bus.io_state), 32'd1);
    bus.io_imem_resp_valid = 1'b1;
    bus.io_imem_resp_data  = word;
    step();
    e = sb.pop_front();
    chk("decode_state", 32'(bus.io_state), 32'd2);
    chk("ir", bus.io_instruction, e.word);
    bus.io_imem_resp_valid = 1'b0;
    bus.io_imem_resp_data  = 32'hDEAD_BEEF;
    step();
    chk("exec_state", 32'(bus.io_state), 32'd3);
    chk("exec_pc_write", 32'(bus.io_pc_write), 32'd0);
    if (halt_exec) bus.io_halt = 1'b1;
    step();
    if (mr | mw) begin
      for (int i = 0; i <= rdy_wait; i++) begin
        chk("memreq_state", 32'(bus.io_state), 32'd4);
        chk("dmem_req_valid", 32'(bus.io_dmem_req_valid), 32'd1);
        chk("dmem_req_write", 32'(bus.io_dmem_req_write), 32'(e.wr));
        bus.io_dmem_req_ready = (i == rdy_wait);
        step();
      end
      bus.io_dmem_req_ready = 1'b0;
      for (int j = 0; j <= resp_wait; j++) begin
        chk("memwait_state", 32'(bus.io_state), 32'd5);
        chk("memwait_dvalid", 32'(bus.io_dmem_req_valid), 32'd0);
        bus.io_dmem_resp_valid = (j == resp_wait);
        step();
      end
      bus.io_dmem_resp_valid = 1'b0;
    end
    chk("wb_state", 32'(bus.io_state), 32'd6);
    chk("wb_pc_write", 32'(bus.io_pc_write), 32'd1);
    chk("wb_reg_we", 32'(bus.io_reg_write_enable), 32'(e.rwe));
    step();
    chk("end_state", 32'(bus.io_state), 32'd0);
    chk("instret", bus.io_instret, e.instret);
    chk("end_strobes", 32'({bus.io_pc_write, bus.io_reg_write_enable}), 32'd0);
    chk("cycles", 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    exp_instret = 32'd0;
    reset = 1'b1;
    bus.io_halt = 1'b0;
    bus.io_imem_req_ready = 1'b1;
    bus.io_imem_resp_valid = 1'b0;
    bus.io_imem_resp_data = 32'd0;
    bus.io_mem_read = 1'b0;
    bus.io_mem_write = 1'b0;
    bus.io_reg_write = 1'b0;
    bus.io_dmem_req_ready = 1'b0;
    bus.io_dmem_resp_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_state", 32'(bus.io_state), 32'd0);
    chk("rst_ir", bus.io_instruction, 32'h0000_0013);
    chk("rst_instret", bus.io_instret, 32'd0);
    chk("rst_imem_valid", 32'(bus.io_imem_req_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_imem_valid", 32'(bus.io_imem_req_valid), 32'd1);

    run_instr(32'h0020_81B3, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);  // ADD
    run_instr(32'h0000_A103, 1'b1, 1'b0, 1'b1, 3, 0, 1'b0);  // LW, ready late
    run_instr(32'h0020_A023, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0);  // SW, resp late
    run_instr(32'h0020_A023, 1'b1, 1'b1, 1'b0, 1, 2, 1'b0);  // both flags -> store

    run_instr(32'h0020_81B3, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);  // halt in EXECUTE
    chk("halted", 32'(bus.io_halted), 32'd1);
    chk("halt_imem_valid", 32'(bus.io_imem_req_valid), 32'd0);
    repeat (2) @(negedge clock);
    chk("halt_parked", 32'(bus.io_state), 32'd0);
    chk("halt_instret", bus.io_instret, exp_instret);

    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    exp_instret = 32'hFFFF_FFFF;
    chk("instret_preset", bus.io_instret, 32'hFFFF_FFFF);
    bus.io_halt = 1'b0;
    #1;
    chk("unhalt_imem_valid", 32'(bus.io_imem_req_valid), 32'd1);
    chk("unhalted", 32'(bus.io_halted), 32'd0);
    run_instr(32'h0020_81B3, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);  // wraps to 0

    bus.io_mem_read = 1'b1;
    bus.io_mem_write = 1'b0;
    @(negedge clock);
    bus.io_imem_resp_valid = 1'b1;
    bus.io_imem_resp_data = 32'h0000_A103;
    @(negedge clock);
    bus.io_imem_resp_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.io_dmem_req_ready = 1'b1;
    @(negedge clock);
    bus.io_dmem_req_ready = 1'b0;
    chk("pre_rst_memwait", 32'(bus.io_state), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(bus.io_state), 32'd0);
    chk("async_rst_ir", bus.io_instruction, 32'h0000_0013);
    chk("async_rst_instret", bus.io_instret, 32'd0);
    chk("async_rst_dvalid", 32'(bus.io_dmem_req_valid), 32'd0);
    @(negedge clock);
    bus.io_imem_req_ready = 1'b0;
    bus.io_dmem_resp_valid = 1'b1;
    reset = 1'b0;
    exp_instret = 32'd0;
    repeat (2) @(negedge clock);
    chk("stray_resp_state", 32'(bus.io_state), 32'd0);
    chk("stray_resp_instret", bus.io_instret, 32'd0);
    bus.io_dmem_resp_valid = 1'b0;
    bus.io_imem_req_ready = 1'b1;
    run_instr(32'h0020_81B3, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
